// File: rtl/io_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | io_responder: 8-byte 6502 I/O window with an LED latch, debounced         |
// | buttons with sticky edge flags, and a snapshot-readable 16-bit tick timer.|
// | Optional IRQ mask and irq output: define IO_RESPONDER_IRQ_EN.             |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module io_responder #(
    parameter logic [15:0] IO_BASE         = 16'hD000,
    parameter int          DEBOUNCE_CYCLES = 4,
    parameter int          PRESCALE        = 100
) (
    input  logic        CLK,
    input  logic        R,
    input  logic [15:0] addr_bus,
    input  logic [7:0]  data_out,
    input  logic        data_write,
    output logic [7:0]  data_in,
    output logic        hit,
    input  logic [3:0]  buttons,
    output logic [7:0]  leds,
    output logic        irq
);

    localparam int c_deb_w = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_pre_w = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_deb_w-1:0] c_deb_last = c_deb_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(PRESCALE - 1);

    logic [7:0]         leds_q, leds_d;
    logic [3:0]         sync1_q, sync1_d;
    logic [3:0]         sync2_q, sync2_d;
    logic [3:0]         deb_q, deb_d;
    logic [c_deb_w-1:0] cnt_q [4];
    logic [c_deb_w-1:0] cnt_d [4];
    logic [3:0]         flag_q, flag_d;
    logic [c_pre_w-1:0] pre_q, pre_d;
    logic [15:0]        tmr_q, tmr_d;
    logic [15:0]        snap_q, snap_d;

    logic       wr_en;
    logic       tick;
    logic [3:0] rise;
    logic [3:0] flag_clr;
    logic [3:0] mask_rd;
    logic [7:0] rd_data;

    assign hit     = (addr_bus[15:3] == IO_BASE[15:3]);
    assign wr_en   = hit & data_write;
    assign leds    = leds_q;
    assign data_in = rd_data;

    always_comb begin
        sync1_d = buttons;
        sync2_d = sync1_q;
        deb_d   = deb_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            // The final stable cycle commits the new level directly, so the
            // counter never has to hold DEBOUNCE_CYCLES itself.
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == c_deb_last) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end

        rise     = deb_d & ~deb_q;
        flag_clr = (wr_en && addr_bus[2:0] == 3'd2) ? data_out[3:0] : 4'b0000;
        flag_d   = (flag_q & ~flag_clr) | rise;

        leds_d = (wr_en && addr_bus[2:0] == 3'd0) ? data_out : leds_q;

        tick  = (pre_q == c_pre_last);
        pre_d = tick ? '0 : pre_q + 1'b1;
        tmr_d = tick ? tmr_q + 16'd1 : tmr_q;
        if (wr_en && addr_bus[2:0] == 3'd5) begin
            pre_d = '0;
            tmr_d = '0;
        end
        snap_d = (wr_en && addr_bus[2:0] == 3'd4) ? tmr_q : snap_q;
    end

    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            leds_q  <= 8'h00;
            sync1_q <= 4'b0000;
            sync2_q <= 4'b0000;
            deb_q   <= 4'b0000;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
            flag_q  <= 4'b0000;
            pre_q   <= '0;
            tmr_q   <= 16'h0000;
            snap_q  <= 16'h0000;
        end else begin
            leds_q  <= leds_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            deb_q   <= deb_d;
            for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
            flag_q  <= flag_d;
            pre_q   <= pre_d;
            tmr_q   <= tmr_d;
            snap_q  <= snap_d;
        end
    end

`ifdef IO_RESPONDER_IRQ_EN
    logic [3:0] mask_q, mask_d;
    logic       irq_q, irq_d;

    always_comb begin
        mask_d = (wr_en && addr_bus[2:0] == 3'd3) ? data_out[3:0] : mask_q;
        irq_d  = |(flag_q & mask_q);
    end

    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            mask_q <= 4'b0000;
            irq_q  <= 1'b0;
        end else begin
            mask_q <= mask_d;
            irq_q  <= irq_d;
        end
    end

    assign mask_rd = mask_q;
    assign irq     = irq_q;
`else
    assign mask_rd = 4'b0000;
    assign irq     = 1'b0;
`endif

    always_comb begin
        rd_data = 8'h00;
        if (hit) begin
            case (addr_bus[2:0])
                3'd0:    rd_data = leds_q;
                3'd1:    rd_data = {4'b0000, deb_q};
                3'd2:    rd_data = {4'b0000, flag_q};
                3'd3:    rd_data = {4'b0000, mask_rd};
                3'd4:    rd_data = snap_q[7:0];
                3'd5:    rd_data = snap_q[15:8];
                default: rd_data = 8'h00;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_io_responder.sv
`default_nettype none
// Testbench for io_responder: directed steps with a scoreboard of expected values.
module tb_io_responder;

    localparam logic [15:0] BASE = 16'hD000;

    logic        CLK = 1'b0;
    logic        R   = 1'b0;
    logic [15:0] addr_bus   = 16'h0000;
    logic [7:0]  data_out   = 8'h00;
    logic        data_write = 1'b0;
    logic [7:0]  data_in;
    logic        hit;
    logic [3:0]  buttons = 4'b0000;
    logic [7:0]  leds;
    logic        irq;

    logic [15:0] addr2 = 16'h0000;
    logic [7:0]  dout2 = 8'h00;
    logic        we2   = 1'b0;
    logic [7:0]  din2;
    logic        hit2;
    logic [3:0]  btn2  = 4'b0000;
    logic [7:0]  leds2;
    logic        irq2;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic [7:0] irq_on;

    typedef struct {
        string      tag;
        logic [7:0] val;
    } exp_t;
    exp_t sb[$];

    always #5 CLK = ~CLK;

    always @(posedge CLK) if (R) cyc <= cyc + 1;

    io_responder #(.IO_BASE(16'hD000), .DEBOUNCE_CYCLES(4), .PRESCALE(100)) dut (
        .CLK(CLK), .R(R), .addr_bus(addr_bus), .data_out(data_out),
        .data_write(data_write), .data_in(data_in), .hit(hit),
        .buttons(buttons), .leds(leds), .irq(irq)
    );

    io_responder #(.IO_BASE(16'hD000), .DEBOUNCE_CYCLES(4), .PRESCALE(1)) dut2 (
        .CLK(CLK), .R(R), .addr_bus(addr2), .data_out(dout2),
        .data_write(we2), .data_in(din2), .hit(hit2),
        .buttons(btn2), .leds(leds2), .irq(irq2)
    );

    task automatic sb_push(input string tag, input logic [7:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic sb_check(input logic [7:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty observed=%h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        sb_push(tag, exp);
        sb_check(obs);
    endtask

    task automatic rd(input string tag, input logic [15:0] a, input logic [7:0] exp);
        logic [15:0] av;
        av = a;
        sb_push(tag, exp);
        sb_push({tag, "_hit"}, {7'b0, av[15:3] == BASE[15:3]});
        addr_bus   = a;
        data_write = 1'b0;
        #1;
        sb_check(data_in);
        sb_check({7'b0, hit});
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        addr_bus   = a;
        data_out   = d;
        data_write = 1'b1;
        step();
        data_write = 1'b0;
        addr_bus   = 16'h0000;
        data_out   = 8'h00;
    endtask

    task automatic rd2(input string tag, input logic [15:0] a, input logic [7:0] exp);
        sb_push(tag, exp);
        addr2 = a;
        #1;
        sb_check(din2);
    endtask

    task automatic wr2(input logic [15:0] a);
        addr2 = a;
        we2   = 1'b1;
        step();
        we2   = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
`ifdef IO_RESPONDER_IRQ_EN
        irq_on = 8'h01;
`else
        irq_on = 8'h00;
`endif
        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_leds", leds, 8'h00);
        chk("rst_irq", {7'b0, irq}, 8'h00);
        rd("rst_btn", 16'hD001, 8'h00);
        rd("rst_edge", 16'hD002, 8'h00);
        rd("rst_tlo", 16'hD004, 8'h00);
        @(negedge CLK);
        R = 1'b1;
        step();

        // LED latch and decode
        wr(16'hD000, 8'hA5);
        chk("leds_a5", leds, 8'hA5);
        rd("rd_led", 16'hD000, 8'hA5);
        rd("rd_outside", 16'hC000, 8'h00);
        wr(16'hC000, 8'h3C);
        chk("leds_outside_wr", leds, 8'hA5);
        wr(16'hD001, 8'hFF);
        wr(16'hD006, 8'hFF);
        rd("rd_btn_ro", 16'hD001, 8'h00);
        rd("rd_off6", 16'hD006, 8'h00);
        rd("rd_off7", 16'hD007, 8'h00);

        // Debounce latency: 2 sync + 4 stable cycles
        buttons = 4'b0001;
        repeat (5) step();
        rd("btn_early", 16'hD001, 8'h00);
        step();
        rd("btn_b0", 16'hD001, 8'h01);
        rd("edge_b0", 16'hD002, 8'h01);

        // 3-cycle glitch on bit1 is rejected
        buttons = 4'b0011;
        repeat (3) step();
        buttons = 4'b0001;
        repeat (10) step();
        rd("glitch_btn", 16'hD001, 8'h01);
        rd("glitch_edge", 16'hD002, 8'h01);

        // Real bit1 press, then write-1-to-clear
        buttons = 4'b0011;
        repeat (6) step();
        rd("btn_b01", 16'hD001, 8'h03);
        rd("edge_b01", 16'hD002, 8'h03);
        wr(16'hD002, 8'h01);
        rd("edge_clr0", 16'hD002, 8'h02);

        // Release bit1 (no flag on falling edge), clear, then set-vs-clear race
        buttons = 4'b0001;
        repeat (8) step();
        rd("btn_rel1", 16'hD001, 8'h01);
        rd("edge_rel1", 16'hD002, 8'h02);
        wr(16'hD002, 8'h02);
        rd("edge_clr1", 16'hD002, 8'h00);
        buttons = 4'b0011;
        repeat (5) step();
        wr(16'hD002, 8'h02);
        rd("set_wins", 16'hD002, 8'h02);
        rd("set_wins_btn", 16'hD001, 8'h03);
        wr(16'hD002, 8'h02);
        rd("edge_clr1b", 16'hD002, 8'h00);

        // Mask register and irq
        wr(16'hD003, 8'hFF);
        rd("mask_ff", 16'hD003, irq_on == 8'h01 ? 8'h0F : 8'h00);
        wr(16'hD003, 8'h01);
        rd("mask_01", 16'hD003, irq_on);
        buttons = 4'b0000;
        repeat (8) step();
        rd("btn_rel_all", 16'hD001, 8'h00);
        chk("irq_idle", {7'b0, irq}, 8'h00);
        buttons = 4'b0001;
        repeat (6) step();
        rd("edge_irq_set", 16'hD002, 8'h01);
        chk("irq_lag", {7'b0, irq}, 8'h00);
        step();
        chk("irq_high", {7'b0, irq}, irq_on);
        wr(16'hD002, 8'h01);
        rd("edge_irq_clr", 16'hD002, 8'h00);
        chk("irq_hold", {7'b0, irq}, irq_on);
        step();
        chk("irq_low", {7'b0, irq}, 8'h00);

        // Timer: clear, 25600 cycles -> 256 ticks, then snapshot
        wr(16'hD005, 8'h00);
        repeat (25600) step();
        wr(16'hD004, 8'h00);
        rd("tmr_hi", 16'hD005, 8'h01);
        rd("tmr_lo", 16'hD004, 8'h00);

        // THI write on the tick edge: clear wins
        wr(16'hD005, 8'h00);
        repeat (99) step();
        wr(16'hD005, 8'h00);
        wr(16'hD004, 8'h00);
        rd("tick_clr_lo", 16'hD004, 8'h00);
        rd("tick_clr_hi", 16'hD005, 8'h00);

        // Wrap on the PRESCALE=1 instance: its counter equals cyc mod 65536
        while (cyc != 65535) step();
        wr2(16'hD004);
        rd2("wrap_ff_lo", 16'hD004, 8'hFF);
        rd2("wrap_ff_hi", 16'hD005, 8'hFF);
        wr2(16'hD004);
        rd2("wrap_00_lo", 16'hD004, 8'h00);
        rd2("wrap_00_hi", 16'hD005, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
